// File: rtl/voice_command_decoder_pkg.sv
// -----------------------------------------------------------------------------
// smart_home_pkg
// Shared definitions for the smart-home front end and controller:
//   - command/mode codes 0..11 (LIGHT_ON .. WATER_ALARM_OFF)
//   - default frame sync byte
//   - error-class codes reported on err_code
//   - decoder FSM state encoding
// -----------------------------------------------------------------------------
package smart_home_pkg;

    localparam logic [3:0] MODE_LIGHT_ON         = 4'd0;
    localparam logic [3:0] MODE_LIGHT_OFF        = 4'd1;
    localparam logic [3:0] MODE_FAN_ON           = 4'd2;
    localparam logic [3:0] MODE_FAN_OFF          = 4'd3;
    localparam logic [3:0] MODE_HEAT_ON          = 4'd4;
    localparam logic [3:0] MODE_HEAT_OFF         = 4'd5;
    localparam logic [3:0] MODE_DOOR_LOCK        = 4'd6;
    localparam logic [3:0] MODE_DOOR_UNLOCK      = 4'd7;
    localparam logic [3:0] MODE_ALARM_ON         = 4'd8;
    localparam logic [3:0] MODE_ALARM_OFF        = 4'd9;
    localparam logic [3:0] MODE_WATER_ALARM_ON   = 4'd10;
    localparam logic [3:0] MODE_WATER_ALARM_OFF  = 4'd11;

    localparam int unsigned MAX_MODE_DEFAULT  = 11;
    localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hA5;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_CHK     = 2'd1;
    localparam logic [1:0] ERR_RANGE   = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_CMD = 2'd1,
        ST_WAIT_CHK = 2'd2
    } vcd_state_e;

endpackage

// File: rtl/voice_command_decoder_if.sv
// -----------------------------------------------------------------------------
// voice_command_decoder_if
// Byte-stream input and command/error outputs of the voice command decoder.
//   rx_data/rx_valid : received byte and its one-cycle strobe
//   ok_google/mode   : one-cycle command strobe and held command code
//   frame_err        : one-cycle rejected-frame pulse
//   err_code         : class of last error (held)
//   err_count        : saturating rejected-frame count
//   busy             : frame in progress
// master = byte source / result consumer, slave = decoder.
// -----------------------------------------------------------------------------
interface voice_command_decoder_if;
    import smart_home_pkg::*;

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       ok_google;
    logic [3:0] mode;
    logic       frame_err;
    logic [1:0] err_code;
    logic [7:0] err_count;
    logic       busy;

    modport master (
        output rx_data, rx_valid,
        input  ok_google, mode, frame_err, err_code, err_count, busy
    );

    modport slave (
        input  rx_data, rx_valid,
        output ok_google, mode, frame_err, err_code, err_count, busy
    );

endinterface

// File: rtl/voice_command_decoder_cmd_timeout_timer.sv
// -----------------------------------------------------------------------------
// cmd_timeout_timer
// Inter-byte idle counter.
//   clk, rst  : clock, asynchronous active-high reset
//   i_clr     : clear count to zero (has priority over i_en)
//   i_en      : count one cycle
//   o_expire  : high in the cycle whose edge would make the count reach
//               TIMEOUT_CYCLES; suppressed when i_clr is high so a byte
//               arriving on that cycle wins
// -----------------------------------------------------------------------------
module cmd_timeout_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);
    import smart_home_pkg::*;

    localparam int unsigned W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expire = i_en && !i_clr && (r_count == LAST);

endmodule

// File: rtl/voice_command_decoder.sv
// -----------------------------------------------------------------------------
// voice_command_decoder
// Parses a byte stream into 3-byte frames {SYNC_BYTE, cmd, SYNC_BYTE^cmd}.
// Valid frames give a one-cycle ok_google with mode=cmd[3:0]; checksum,
// range and inter-byte timeout failures give a one-cycle frame_err, update
// err_code and bump the saturating err_count.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : voice_command_decoder_if.slave (byte input, result outputs)
// -----------------------------------------------------------------------------
module voice_command_decoder
    import smart_home_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEFAULT,
    parameter int unsigned MAX_MODE       = MAX_MODE_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    voice_command_decoder_if.slave  bus
);

    localparam logic [7:0] MAX_CMD = 8'(MAX_MODE);

    vcd_state_e r_state, w_state_next;
    logic [7:0] r_cmd, w_cmd_next;
    logic       r_ok, w_ok_next;
    logic [3:0] r_mode, w_mode_next;
    logic       r_ferr, w_ferr_next;
    logic [1:0] r_err_code, w_err_code_next;
    logic [7:0] r_err_count, w_err_count_next;

    logic       w_reject;
    logic [1:0] w_reject_code;
    logic       w_expire;
    logic       w_tmr_clr;
    logic       w_tmr_en;

    // Timer runs only inside a frame; any strobed byte restarts it.
    assign w_tmr_en  = (r_state != ST_IDLE);
    assign w_tmr_clr = bus.rx_valid || (r_state == ST_IDLE);

    cmd_timeout_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (w_tmr_clr),
        .i_en     (w_tmr_en),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cmd       <= '0;
            r_ok        <= 1'b0;
            r_mode      <= '0;
            r_ferr      <= 1'b0;
            r_err_code  <= ERR_NONE;
            r_err_count <= '0;
        end else begin
            r_state     <= w_state_next;
            r_cmd       <= w_cmd_next;
            r_ok        <= w_ok_next;
            r_mode      <= w_mode_next;
            r_ferr      <= w_ferr_next;
            r_err_code  <= w_err_code_next;
            r_err_count <= w_err_count_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_cmd_next       = r_cmd;
        w_ok_next        = 1'b0;
        w_mode_next      = r_mode;
        w_ferr_next      = 1'b0;
        w_err_code_next  = r_err_code;
        w_err_count_next = r_err_count;
        w_reject         = 1'b0;
        w_reject_code    = ERR_NONE;

        case (r_state)
            ST_IDLE: begin
                if (bus.rx_valid && (bus.rx_data == SYNC_BYTE)) begin
                    w_state_next = ST_WAIT_CMD;
                end
            end
            ST_WAIT_CMD: begin
                if (bus.rx_valid) begin
                    w_cmd_next   = bus.rx_data;
                    w_state_next = ST_WAIT_CHK;
                end else if (w_expire) begin
                    w_reject      = 1'b1;
                    w_reject_code = ERR_TIMEOUT;
                    w_state_next  = ST_IDLE;
                end
            end
            ST_WAIT_CHK: begin
                if (bus.rx_valid) begin
                    w_state_next = ST_IDLE;
                    if (bus.rx_data != (SYNC_BYTE ^ r_cmd)) begin
                        w_reject      = 1'b1;
                        w_reject_code = ERR_CHK;
                    end else if (r_cmd > MAX_CMD) begin
                        w_reject      = 1'b1;
                        w_reject_code = ERR_RANGE;
                    end else begin
                        w_ok_next   = 1'b1;
                        w_mode_next = r_cmd[3:0];
                    end
                end else if (w_expire) begin
                    w_reject      = 1'b1;
                    w_reject_code = ERR_TIMEOUT;
                    w_state_next  = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        if (w_reject) begin
            w_ferr_next     = 1'b1;
            w_err_code_next = w_reject_code;
            if (r_err_count != '1) begin
                w_err_count_next = r_err_count + 8'd1;
            end
        end
    end

    assign bus.ok_google = r_ok;
    assign bus.mode      = r_mode;
    assign bus.frame_err = r_ferr;
    assign bus.err_code  = r_err_code;
    assign bus.err_count = r_err_count;
    assign bus.busy      = (r_state != ST_IDLE);

endmodule
